// File: rtl/bus_pkg.sv
// Shared definitions for the bus device port: destination-ID type and width,
// counter saturation value, and a helper that extracts the destination ID
// from the top byte of a packet.
package bus_pkg;

    localparam int unsigned DEST_W    = 8;
    // Widest packet get_dest() accepts; narrower packets are zero-extended.
    localparam int unsigned PKT_W_MAX = 64;
    localparam logic [7:0]  CNT_MAX   = 8'hFF;

    typedef logic [DEST_W-1:0] dest_t;

    // Destination ID is the top DEST_W bits of a pkt_w-bit packet.
    function automatic dest_t get_dest(input logic [PKT_W_MAX-1:0] pkt,
                                       input int unsigned pkt_w);
        return dest_t'(pkt >> (pkt_w - DEST_W));
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Show-ahead synchronous FIFO.
// Ports:
//   clk, reset (async, active-low)
//   wr/din   : enqueue strobe and data
//   rd       : dequeue strobe (ignored while empty)
//   dout     : head entry, 0 while empty
//   empty    : count == 0
//   full     : count == depth
//   wr_drop  : write rejected this cycle (full and no effective read)
module fifo_sync #(
    parameter int unsigned width = 16,
    parameter int unsigned depth = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             wr_drop
);

    localparam int unsigned PtrW = $clog2(depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [width-1:0] mem_q [depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             rd_en, wr_en;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CntW'(depth));
        rd_en   = rd && !empty;
        // A read in the same cycle frees the slot a full queue needs.
        wr_en   = wr && (!full || rd_en);
        wr_drop = wr && !wr_en;
        dout    = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/bus_dev_port.sv
// Device-side endpoint of the bus arbiter. Holds a TX queue drained by the
// bus and an RX queue filled by the bus, an RX destination filter, and
// saturating drop/filter counters.
// Ports:
//   clk, reset (async, active-low)
//   tx_wr/tx_din/tx_full    : host side of TX queue
//   pndng/D_pop/pop         : bus side of TX queue
//   push/D_push             : bus delivery into RX (address filtered)
//   rx_rd/rx_dout/rx_pndng/rx_full : host side of RX queue
//   ovf_cnt                 : packets dropped on full TX or RX
//   flt_cnt                 : bus pushes rejected by the address filter
module bus_dev_port
    import bus_pkg::*;
#(
    parameter int unsigned pckg_sz   = 16,
    parameter int unsigned depth     = 8,
    parameter dest_t       id        = 8'h00,
    parameter dest_t       broadcast = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_din,
    output logic               tx_full,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               rx_rd,
    output logic [pckg_sz-1:0] rx_dout,
    output logic               rx_pndng,
    output logic               rx_full,
    output logic [7:0]         ovf_cnt,
    output logic [7:0]         flt_cnt
);

    logic       tx_empty, rx_empty;
    logic       tx_drop, rx_drop;
    logic       accept, flt_inc;
    dest_t      dest;
    logic [8:0] ovf_sum;
    logic [7:0] ovf_q, ovf_d, flt_q, flt_d;

    fifo_sync #(
        .width (pckg_sz),
        .depth (depth)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (tx_wr),
        .rd      (pop),
        .din     (tx_din),
        .dout    (D_pop),
        .empty   (tx_empty),
        .full    (tx_full),
        .wr_drop (tx_drop)
    );

    fifo_sync #(
        .width (pckg_sz),
        .depth (depth)
    ) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (accept),
        .rd      (rx_rd),
        .din     (D_push),
        .dout    (rx_dout),
        .empty   (rx_empty),
        .full    (rx_full),
        .wr_drop (rx_drop)
    );

    always_comb begin
        dest    = get_dest(PKT_W_MAX'(D_push), pckg_sz);
        accept  = push && ((dest == id) || (dest == broadcast));
        flt_inc = push && !accept;

        // Both queues may drop in the same cycle, so the increment is 0..2.
        ovf_sum = {1'b0, ovf_q} + 9'(tx_drop) + 9'(rx_drop);
        ovf_d   = (ovf_sum > {1'b0, CNT_MAX}) ? CNT_MAX : ovf_sum[7:0];
        flt_d   = (flt_inc && (flt_q != CNT_MAX)) ? flt_q + 8'd1 : flt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= '0;
            flt_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            flt_q <= flt_d;
        end
    end

    assign pndng    = !tx_empty;
    assign rx_pndng = !rx_empty;
    assign ovf_cnt  = ovf_q;
    assign flt_cnt  = flt_q;

endmodule

// File: doc/bus_dev_port.md
Name: bus_dev_port

Overview:
- Device-side endpoint of the bs_gnrtr_n_rbtr bus; one instance per device.
- Presents the FIFO-style terminal the arbiter expects: a TX queue the bus drains (pndng/pop/D_pop) and an RX queue the bus fills (push/D_push).
- Host logic enqueues outbound packets and dequeues inbound packets addressed to this device or to broadcast.
- Replaces the behavioural FIFO model in the bench with synthesizable RTL.

Parameters:
- pckg_sz, 16, packet width in bits; bits [pckg_sz-1 -: 8] hold the destination ID.
- depth, 8, entries per queue; power of 2, at least 2.
- id, 0, this device's 8-bit ID.
- broadcast, 8'hFF, destination ID that is accepted by every device.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- tx_wr  in  1  host enqueue strobe.
- tx_din  in  pckg_sz  host outbound packet.
- tx_full  out  1  TX queue full.
- pndng  out  1  TX queue non-empty (to bus).
- D_pop  out  pckg_sz  TX head packet (to bus).
- pop  in  1  bus dequeue strobe.
- push  in  1  bus delivery strobe.
- D_push  in  pckg_sz  packet delivered by the bus.
- rx_rd  in  1  host dequeue strobe.
- rx_dout  out  pckg_sz  RX head packet.
- rx_pndng  out  1  RX queue non-empty.
- rx_full  out  1  RX queue full.
- ovf_cnt  out  8  dropped-packet counter: TX overflow plus RX overflow.
- flt_cnt  out  8  counter of bus pushes rejected by the address filter.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - all pointers and counters go to 0;
  - pndng=0, rx_pndng=0, tx_full=0, rx_full=0;
  - D_pop and rx_dout go to 0, as does the storage content seen at the heads.
  - A reset asserted mid-transfer discards all queued packets; nothing is replayed.
- Both queues are show-ahead:
  - the head is valid on the output whenever the queue is non-empty;
  - dequeue advances the head on the next rising edge.
- Latency: an enqueue at edge N is visible on the head/pndng after edge N when the queue was empty; there is no combinational write-to-read path.
- TX queue:
  - tx_wr with not full → write tx_din.
  - pop with pndng=1 → advance head.
  - pop with pndng=0 → ignored, no state change.
  - tx_wr while full and no pop → packet dropped, ovf_cnt+1.
  - tx_wr while full with a pop in the same cycle → write accepted; occupancy stays at depth.
  - tx_wr and pop on an empty queue → write accepted; pop ignored.
- RX address filter: dest = D_push[pckg_sz-1 -: 8]. Accept when dest==id or dest==broadcast; otherwise drop and flt_cnt+1.
- RX queue:
  - accepted push with not full → write.
  - accepted push while full → rx_rd in the same cycle frees the slot, otherwise drop with ovf_cnt+1.
  - rx_rd on empty → ignored.
- Counters:
  - saturate at 8'hFF; no wrap.
  - both overflow sources in the same cycle → ovf_cnt+2, saturating.
- Occupancy: count width $clog2(depth)+1. full = count==depth; empty = count==0. Pointers wrap modulo depth.
- Packet payload is never modified; the ID field is not stripped.

Decomposition:
- Shared package bus_pkg:
  - typedef dest_t (8-bit);
  - function get_dest(pkt);
  - constant DEST_W=8;
  - counter saturation constant CNT_MAX=8'hFF.
- Sub-module fifo_sync (params width, depth):
  - inputs wr, rd, din; outputs dout, empty, full, wr_drop;
  - simultaneous rd/wr rules as above.
  - Instantiated twice.
- Top holds the filter and the counters.

Test Plan:
- Reset: hold reset=0 with tx_wr=1 and push=1 active → pndng=0, rx_pndng=0, ovf_cnt=0, flt_cnt=0 after release.
- TX order: id=2; write 16'h0111, 16'h0222, 16'h0333; pulse pop three times → D_pop shows 0111, 0222, 0333 in order; pndng=0 after the third pop; a fourth pop is ignored.
- TX overflow: write 9 packets with depth=8 and no pop → tx_full=1, ovf_cnt=1. A 10th write with a simultaneous pop is accepted, ovf_cnt stays 1, and the queue still holds 8.
- RX filter: id=2; push 16'h02AA, 16'h03BB, 16'hFFCC → rx_dout reads 02AA then FFCC; flt_cnt=1.
- RX overflow: fill RX with 8 packets using dest=02, push a 9th → dropped, ovf_cnt=1. A push with simultaneous rx_rd is accepted.
- Saturation and reset: force 300 filtered pushes → flt_cnt=8'hFF. Assert reset mid-stream → all queues empty and both counters 0.
